// File: rtl/agc_pkg.sv
// Shared AGC definitions for the instruction fetch slice: address/word
// widths, parity bit position, fetch FSM state encoding and a parity helper.
package agc_pkg;

  localparam int unsigned AGC_ADDR_W = 12;
  localparam int unsigned AGC_WORD_W = 16;
  localparam int unsigned PARITY_BIT = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  // AGC words carry odd parity: an even number of ones means the word is bad.
  function automatic logic parity_bad(input logic [AGC_WORD_W-1:0] w);
    return ~^w;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: 2-entry {addr, word} queue between memory and decode.
// Ports:
//   clk, reset            clock, async active-high reset
//   clear                 drop all entries (wins over push/pop)
//   push, push_addr/word  enqueue one entry
//   pop                   dequeue head (ignored when empty)
//   count                 number of valid entries, 0..2
//   head_valid/addr/word  registered head entry
module fetch_fifo
  import agc_pkg::*;
#(
  parameter int unsigned AW = AGC_ADDR_W,
  parameter int unsigned DW = AGC_WORD_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          push,
  input  logic [AW-1:0] push_addr,
  input  logic [DW-1:0] push_word,
  input  logic          pop,
  output logic [1:0]    count,
  output logic          head_valid,
  output logic [AW-1:0] head_addr,
  output logic [DW-1:0] head_word
);

  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] word0, word1;
  logic [1:0]    cnt;
  logic          pop_en;
  logic          push_en;

  assign pop_en  = pop & (cnt != 2'd0);
  assign push_en = push & ((cnt != 2'd2) | pop_en);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      addr0 <= '0;
      addr1 <= '0;
      word0 <= '0;
      word1 <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else begin
      unique case ({push_en, pop_en})
        2'b10: begin
          if (cnt == 2'd0) begin
            addr0 <= push_addr;
            word0 <= push_word;
          end else begin
            addr1 <= push_addr;
            word1 <= push_word;
          end
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          addr0 <= addr1;
          word0 <= word1;
          cnt   <= cnt - 2'd1;
        end
        2'b11: begin
          // Simultaneous push/pop: count holds, new entry lands behind
          // whatever survives the pop.
          if (cnt == 2'd1) begin
            addr0 <= push_addr;
            word0 <= push_word;
          end else begin
            addr0 <= addr1;
            word0 <= word1;
            addr1 <= push_addr;
            word1 <= push_word;
          end
        end
        default: ;
      endcase
    end
  end

  assign count      = cnt;
  assign head_valid = (cnt != 2'd0);
  assign head_addr  = addr0;
  assign head_word  = word0;

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: fetches one word at a time from memory at the PC address,
// advances the PC only when a word returns, and queues words for decode.
// Ports:
//   clk, reset                      clock, async active-high reset
//   pc_addr / pc_enable             PC value in, PC advance strobe out
//   mem_req/mem_addr/mem_ack/mem_data  memory read handshake
//   flush                           discard queued and in-flight fetches
//   instr_valid/ready/word/addr     decode-side queue head
//   parity_err                      head word fails odd parity
module instr_fetch
  import agc_pkg::*;
#(
  parameter int unsigned ADDR_W = AGC_ADDR_W,
  parameter int unsigned WORD_W = AGC_WORD_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_addr,
  output logic              pc_enable,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [WORD_W-1:0] mem_data,
  input  logic              flush,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [WORD_W-1:0] instr_word,
  output logic [ADDR_W-1:0] instr_addr,
  output logic              parity_err
);

  fetch_state_t      state, state_n;
  logic              req_n;
  logic [ADDR_W-1:0] addr_n;
  logic              push;
  logic [1:0]        count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      mem_req  <= 1'b0;
      mem_addr <= '0;
    end else begin
      state    <= state_n;
      mem_req  <= req_n;
      mem_addr <= addr_n;
    end
  end

  always_comb begin
    state_n   = state;
    req_n     = mem_req;
    addr_n    = mem_addr;
    push      = 1'b0;
    pc_enable = 1'b0;
    unique case (state)
      IDLE: begin
        if ((count != 2'd2) && !flush) begin
          req_n   = 1'b1;
          addr_n  = pc_addr;
          state_n = WAIT;
        end
      end
      WAIT: begin
        if (mem_ack) begin
          req_n   = 1'b0;
          state_n = IDLE;
          if (!flush) begin
            push      = 1'b1;
            pc_enable = 1'b1;
          end
        end else if (flush) begin
          // Request must stay up until memory answers; its word is dropped.
          state_n = DRAIN;
        end
      end
      DRAIN: begin
        if (mem_ack) begin
          req_n   = 1'b0;
          state_n = IDLE;
        end
      end
      default: begin
        req_n   = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  fetch_fifo #(
    .AW (ADDR_W),
    .DW (WORD_W)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .clear      (flush),
    .push       (push),
    .push_addr  (mem_addr),
    .push_word  (mem_data),
    .pop        (instr_valid & instr_ready),
    .count      (count),
    .head_valid (instr_valid),
    .head_addr  (instr_addr),
    .head_word  (instr_word)
  );

  assign parity_err = instr_valid & parity_bad(instr_word);

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  logic        clk;
  logic        reset;
  logic [11:0] pc_addr;
  logic        pc_enable;
  logic        mem_req;
  logic [11:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_data;
  logic        flush;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr_word;
  logic [11:0] instr_addr;
  logic        parity_err;

  int n_checks = 0;
  int n_fail   = 0;

  instr_fetch #(
    .ADDR_W (12),
    .WORD_W (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pc_addr     (pc_addr),
    .pc_enable   (pc_enable),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_data    (mem_data),
    .flush       (flush),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_word  (instr_word),
    .instr_addr  (instr_addr),
    .parity_err  (parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Settle point for checks: falling edge.
  task automatic to_neg();
    @(negedge clk);
  endtask

  // Rising edge, then act as the PC: advance when pc_enable was high.
  task automatic to_pos();
    logic pe;
    pe = pc_enable;
    @(posedge clk);
    #1;
    if (pe) pc_addr = pc_addr + 12'd1;
  endtask

  task automatic step();
    to_neg();
    to_pos();
  endtask

  task automatic do_reset(input logic [11:0] pc);
    reset       = 1'b1;
    mem_ack     = 1'b0;
    mem_data    = '0;
    flush       = 1'b0;
    instr_ready = 1'b0;
    pc_addr     = pc;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_ack = 1'b0; mem_data = '0; flush = 1'b0;
    instr_ready = 1'b0; pc_addr = '0;
    to_neg();
    n_checks++;
    if ({mem_req, instr_valid, pc_enable, parity_err} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: got req/val/pe/perr=%b expected 0000",
               {mem_req, instr_valid, pc_enable, parity_err});
    end
    n_checks++;
    if ({mem_addr, instr_addr, instr_word} !== 40'd0) begin
      n_fail++;
      $display("FAIL reset_regs: mem_addr=%h instr_addr=%h instr_word=%h expected 0",
               mem_addr, instr_addr, instr_word);
    end
    to_pos();
    reset = 1'b0;
    step();
    n_checks++;
    if (mem_req !== 1'b1 || mem_addr !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_first_req: req=%b addr=%h expected 1/000", mem_req, mem_addr);
    end
    // Reset lands in the middle of WAIT.
    reset = 1'b1;
    #1;
    n_checks++;
    if (mem_req !== 1'b0 || instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: req=%b valid=%b expected 0/0", mem_req, instr_valid);
    end
    reset = 1'b0;
    step();
    n_checks++;
    if (mem_req !== 1'b1 || mem_addr !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_rerequest: req=%b addr=%h expected 1/000", mem_req, mem_addr);
    end
  endtask

  task automatic test_single();
    do_reset(12'h000);
    step();
    mem_ack = 1'b1; mem_data = 16'h8001;
    to_neg();
    n_checks++;
    if (pc_enable !== 1'b1) begin
      n_fail++;
      $display("FAIL single_pc_enable: got %b expected 1", pc_enable);
    end
    to_pos();
    mem_ack = 1'b0;
    to_neg();
    n_checks++;
    if (pc_enable !== 1'b0 || mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL single_after_ack: pe=%b req=%b expected 0/0", pc_enable, mem_req);
    end
    n_checks++;
    // 0x8001 has two ones, so odd parity fails.
    if (instr_valid !== 1'b1 || instr_word !== 16'h8001 || instr_addr !== 12'h000 ||
        parity_err !== 1'b1) begin
      n_fail++;
      $display("FAIL single_head: valid=%b word=%h addr=%h perr=%b expected 1/8001/000/1",
               instr_valid, instr_word, instr_addr, parity_err);
    end
    n_checks++;
    if (pc_addr !== 12'h001) begin
      n_fail++;
      $display("FAIL single_pc_step: pc=%h expected 001", pc_addr);
    end
    to_pos();
  endtask

  task automatic test_queue_full();
    int pulses;
    pulses = 0;
    do_reset(12'h000);
    for (int i = 0; i < 8; i++) begin
      mem_ack  = mem_req;
      mem_data = {4'hA, mem_addr};
      to_neg();
      if (pc_enable) pulses++;
      to_pos();
    end
    mem_ack = 1'b0;
    to_neg();
    n_checks++;
    if (pulses !== 2 || pc_addr !== 12'h002) begin
      n_fail++;
      $display("FAIL full_fetch_count: pulses=%0d pc=%h expected 2/002", pulses, pc_addr);
    end
    n_checks++;
    if (mem_req !== 1'b0 || instr_valid !== 1'b1 || instr_addr !== 12'h000 ||
        instr_word !== 16'hA000) begin
      n_fail++;
      $display("FAIL full_stall: req=%b valid=%b addr=%h word=%h expected 0/1/000/A000",
               mem_req, instr_valid, instr_addr, instr_word);
    end
    instr_ready = 1'b1;
    to_pos();
    instr_ready = 1'b0;
    to_neg();
    n_checks++;
    if (mem_req !== 1'b0 || instr_addr !== 12'h001 || instr_word !== 16'hA001) begin
      n_fail++;
      $display("FAIL full_pop: req=%b addr=%h word=%h expected 0/001/A001",
               mem_req, instr_addr, instr_word);
    end
    to_pos();
    n_checks++;
    if (mem_req !== 1'b1 || mem_addr !== 12'h002) begin
      n_fail++;
      $display("FAIL full_resume: req=%b addr=%h expected 1/002", mem_req, mem_addr);
    end
    // Push and pop together at count 1.
    mem_ack = 1'b1; mem_data = 16'hA002; instr_ready = 1'b1;
    to_neg();
    to_pos();
    mem_ack = 1'b0; instr_ready = 1'b0;
    to_neg();
    n_checks++;
    if (instr_valid !== 1'b1 || instr_addr !== 12'h002 || instr_word !== 16'hA002) begin
      n_fail++;
      $display("FAIL back_to_back: valid=%b addr=%h word=%h expected 1/002/A002",
               instr_valid, instr_addr, instr_word);
    end
    to_pos();
  endtask

  task automatic test_flush_wait();
    do_reset(12'h100);
    step();
    mem_ack = 1'b1; mem_data = 16'h4000;
    step();
    mem_ack = 1'b0;
    step();
    to_neg();
    n_checks++;
    if (instr_valid !== 1'b1 || instr_addr !== 12'h100 || mem_req !== 1'b1 ||
        mem_addr !== 12'h101) begin
      n_fail++;
      $display("FAIL flush_setup: valid=%b iaddr=%h req=%b maddr=%h expected 1/100/1/101",
               instr_valid, instr_addr, mem_req, mem_addr);
    end
    flush = 1'b1;
    to_pos();
    flush   = 1'b0;
    pc_addr = 12'h2AA;
    for (int i = 0; i < 2; i++) begin
      to_neg();
      n_checks++;
      if (mem_req !== 1'b1 || mem_addr !== 12'h101 || instr_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_drain_hold: req=%b addr=%h valid=%b expected 1/101/0",
                 mem_req, mem_addr, instr_valid);
      end
      to_pos();
    end
    mem_ack = 1'b1; mem_data = 16'h7777;
    to_neg();
    n_checks++;
    if (pc_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_drain_pe: got %b expected 0", pc_enable);
    end
    to_pos();
    mem_ack = 1'b0;
    to_neg();
    n_checks++;
    if (mem_req !== 1'b0 || instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_drain_done: req=%b valid=%b expected 0/0", mem_req, instr_valid);
    end
    to_pos();
    n_checks++;
    if (mem_req !== 1'b1 || mem_addr !== 12'h2AA) begin
      n_fail++;
      $display("FAIL flush_jump_req: req=%b addr=%h expected 1/2AA", mem_req, mem_addr);
    end
  endtask

  task automatic test_flush_ack();
    do_reset(12'h010);
    step();
    mem_ack = 1'b1; mem_data = 16'h1234; flush = 1'b1;
    to_neg();
    n_checks++;
    if (pc_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_ack_pe: got %b expected 0", pc_enable);
    end
    to_pos();
    mem_ack = 1'b0; flush = 1'b0;
    to_neg();
    n_checks++;
    if (instr_valid !== 1'b0 || mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_ack_drop: valid=%b req=%b expected 0/0", instr_valid, mem_req);
    end
    to_pos();
    n_checks++;
    if (mem_req !== 1'b1 || mem_addr !== 12'h010) begin
      n_fail++;
      $display("FAIL flush_ack_refetch: req=%b addr=%h expected 1/010", mem_req, mem_addr);
    end
  endtask

  task automatic test_parity();
    do_reset(12'h000);
    step();
    mem_ack = 1'b1; mem_data = 16'h0001;
    step();
    mem_ack = 1'b0;
    to_neg();
    n_checks++;
    if (instr_valid !== 1'b1 || instr_word !== 16'h0001 || parity_err !== 1'b0) begin
      n_fail++;
      $display("FAIL parity_odd: valid=%b word=%h perr=%b expected 1/0001/0",
               instr_valid, instr_word, parity_err);
    end
    instr_ready = 1'b1;
    to_pos();
    instr_ready = 1'b0;
    to_neg();
    n_checks++;
    if (instr_valid !== 1'b0 || parity_err !== 1'b0) begin
      n_fail++;
      $display("FAIL parity_empty: valid=%b perr=%b expected 0/0", instr_valid, parity_err);
    end
    mem_ack = 1'b1; mem_data = 16'h0003;
    to_pos();
    mem_ack = 1'b0;
    to_neg();
    n_checks++;
    if (instr_valid !== 1'b1 || instr_word !== 16'h0003 || instr_addr !== 12'h001 ||
        parity_err !== 1'b1) begin
      n_fail++;
      $display("FAIL parity_even: valid=%b word=%h addr=%h perr=%b expected 1/0003/001/1",
               instr_valid, instr_word, instr_addr, parity_err);
    end
    to_pos();
  endtask

  initial begin
    test_reset();
    test_single();
    test_queue_full();
    test_flush_wait();
    test_flush_ack();
    test_parity();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
